// File: rtl/uart_tx_block.sv
// uart_tx_block: serial transmitter for the lab UART link.
// It sends one frame per accepted byte: a start bit, the data bits LSB first,
// then a stop bit.
// Optional feature macro: UART_TX_PARITY_EN. When it is defined, an even-parity
// bit is inserted between the last data bit and the stop bit.
// Outputs are registered and go to their idle values as soon as n_rst is asserted.
module uart_tx_block #(
    parameter int DATA_BITS  = 8,
    parameter int BIT_PERIOD = 10
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 serial_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CW = $clog2(BIT_PERIOD) + 1;
    localparam int BW = $clog2(DATA_BITS) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BIT_PERIOD);
    localparam logic [BW-1:0] BIT_MAX = BW'(DATA_BITS);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;     // clock within the current bit, 1..BIT_PERIOD
    logic [BW-1:0]          bit_q, bit_d;     // data bit index, 1..DATA_BITS
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;     // even parity of the latched byte
    logic                   serial_q, serial_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   bit_end;

    assign bit_end    = (cnt_q == CNT_MAX);
    assign serial_out = serial_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;

    // State and datapath registers; reset returns the line to idle immediately.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic. Each output register is loaded with the value of the bit
    // that starts on the next edge, so the line changes only at bit boundaries.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        serial_d = serial_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? CW'(1) : cnt_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                cnt_d    = '0;
                bit_d    = '0;
                serial_d = 1'b1;
                busy_d   = 1'b0;
                if (tx_start) begin
                    state_d  = S_START;
                    shift_d  = tx_data;
                    par_d    = ^tx_data;
                    serial_d = 1'b0;
                    busy_d   = 1'b1;
                    cnt_d    = CW'(1);
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d  = S_DATA;
                    serial_d = shift_q[0];
                    shift_d  = shift_q >> 1;
                    bit_d    = BW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == BIT_MAX) begin
                        bit_d    = '0;
`ifdef UART_TX_PARITY_EN
                        state_d  = S_PARITY;
                        serial_d = par_q;
`else
                        state_d  = S_STOP;
                        serial_d = 1'b1;
`endif
                    end else begin
                        serial_d = shift_q[0];
                        shift_d  = shift_q >> 1;
                        bit_d    = bit_q + BW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d  = S_STOP;
                    serial_d = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    state_d  = S_IDLE;
                    serial_d = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                serial_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

endmodule
